// File: rtl/nec_ir_receiver.sv
// NEC infrared frame decoder: synchronizes the raw receiver line, measures level widths
// and delivers validated key codes, repeat pulses and a hold window.
module nec_ir_receiver #(
    parameter int LEAD_LOW_MIN    = 400000,
    parameter int LEAD_HIGH_MIN   = 200000,
    parameter int REPEAT_HIGH_MIN = 100000,
    parameter int BIT_ONE_MIN     = 56000,
    parameter int TIMEOUT         = 700000,
    parameter int REPEAT_WINDOW   = 6000000,
    parameter int CNT_W           = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ir_in,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic [7:0] addr,
    output logic       repeat_pulse,
    output logic       key_held,
    output logic       frame_error
);

    localparam logic [CNT_W-1:0] LEAD_LOW_C    = CNT_W'(LEAD_LOW_MIN);
    localparam logic [CNT_W-1:0] LEAD_HIGH_C   = CNT_W'(LEAD_HIGH_MIN);
    localparam logic [CNT_W-1:0] REPEAT_HIGH_C = CNT_W'(REPEAT_HIGH_MIN);
    localparam logic [CNT_W-1:0] BIT_ONE_C     = CNT_W'(BIT_ONE_MIN);
    localparam logic [CNT_W-1:0] TIMEOUT_C     = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] WINDOW_C      = CNT_W'(REPEAT_WINDOW);

    typedef enum logic [2:0] {
        IDLE, LEAD_LOW, LEAD_HIGH, BIT_MARK, BIT_SPACE, STOP_MARK, REPEAT_MARK
    } state_t;

    state_t           state;
    logic             sync1, sync2, prev;
    logic             rise, fall, timeout;
    logic [CNT_W-1:0] level_cnt;
    logic [CNT_W-1:0] window_cnt;
    logic [31:0]      data;
    logic [4:0]       bit_idx;

    assign rise     = sync2 & ~prev;
    assign fall     = ~sync2 & prev;
    assign timeout  = (state != IDLE) && (level_cnt == TIMEOUT_C);
    assign key_held = (window_cnt != '0);

    // Line idles high, so the synchronizer resets to 1 to avoid a false fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            prev      <= 1'b1;
            level_cnt <= '0;
        end else begin
            sync1 <= ir_in;
            sync2 <= sync1;
            prev  <= sync2;
            if (rise || fall)
                level_cnt <= '0;
            else if (level_cnt != TIMEOUT_C)
                level_cnt <= level_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            data         <= '0;
            bit_idx      <= '0;
            window_cnt   <= '0;
            key_valid    <= 1'b0;
            key_code     <= '0;
            addr         <= '0;
            repeat_pulse <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            key_valid    <= 1'b0;
            repeat_pulse <= 1'b0;
            frame_error  <= 1'b0;
            // A reload issued below overrides this decrement.
            if (window_cnt != '0)
                window_cnt <= window_cnt - CNT_W'(1);

            if (timeout) begin
                frame_error <= 1'b1;
                state       <= IDLE;
            end else begin
                case (state)
                    IDLE:
                        if (fall) state <= LEAD_LOW;
                    LEAD_LOW:
                        if (rise) state <= (level_cnt >= LEAD_LOW_C) ? LEAD_HIGH : IDLE;
                    LEAD_HIGH:
                        if (fall) begin
                            if (level_cnt >= LEAD_HIGH_C) begin
                                bit_idx <= '0;
                                state   <= BIT_MARK;
                            end else if (level_cnt >= REPEAT_HIGH_C) begin
                                state <= REPEAT_MARK;
                            end else begin
                                frame_error <= 1'b1;
                                state       <= IDLE;
                            end
                        end
                    BIT_MARK:
                        if (rise) state <= BIT_SPACE;
                    BIT_SPACE:
                        if (fall) begin
                            data[bit_idx] <= (level_cnt >= BIT_ONE_C);
                            if (bit_idx == 5'd31) begin
                                state <= STOP_MARK;
                            end else begin
                                bit_idx <= bit_idx + 5'd1;
                                state   <= BIT_MARK;
                            end
                        end
                    STOP_MARK:
                        if (rise) begin
                            // Only the command byte carries a checked complement.
                            if (data[31:24] == ~data[23:16]) begin
                                key_code   <= data[23:16];
                                addr       <= data[7:0];
                                key_valid  <= 1'b1;
                                window_cnt <= WINDOW_C;
                            end else begin
                                frame_error <= 1'b1;
                            end
                            state <= IDLE;
                        end
                    REPEAT_MARK:
                        if (rise) begin
                            if (key_held) begin
                                repeat_pulse <= 1'b1;
                                window_cnt   <= WINDOW_C;
                            end
                            state <= IDLE;
                        end
                    default:
                        state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nec_ir_receiver.sv
// Bench for nec_ir_receiver: drives NEC waveforms and predicts events from frame contents
// and the hold-window timing rules.
module tb_nec_ir_receiver;

    localparam int LL = 40, LH = 20, RH = 10, B1 = 6, TO = 70, RW = 600;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ir_in = 1'b1;
    logic       key_valid, repeat_pulse, key_held, frame_error;
    logic [7:0] key_code, addr;

    nec_ir_receiver #(
        .LEAD_LOW_MIN(LL), .LEAD_HIGH_MIN(LH), .REPEAT_HIGH_MIN(RH),
        .BIT_ONE_MIN(B1), .TIMEOUT(TO), .REPEAT_WINDOW(RW), .CNT_W(24)
    ) dut (
        .clk(clk), .rst(rst), .ir_in(ir_in), .key_valid(key_valid), .key_code(key_code),
        .addr(addr), .repeat_pulse(repeat_pulse), .key_held(key_held), .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 1 = key_valid, 2 = repeat_pulse, 3 = frame_error
    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] code;
        logic [7:0] adr;
    } ev_t;

    ev_t ev_q[$];
    int  multi = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (int'(key_valid) + int'(repeat_pulse) + int'(frame_error) > 1) multi <= multi + 1;
            if (key_valid)    ev_q.push_back('{cyc, 1, key_code, addr});
            if (repeat_pulse) ev_q.push_back('{cyc, 2, key_code, addr});
            if (frame_error)  ev_q.push_back('{cyc, 3, key_code, addr});
        end
    end

    int checks = 0, errors = 0;

    // Reference model state
    int         held_until = 0;
    logic [7:0] m_code = 8'h00, m_addr = 8'h00;
    int         exp_kind, exp_cyc;

    task automatic model_frame(input logic [7:0] a, input logic [7:0] c, input logic [7:0] ci, input int rise);
        exp_cyc = rise + 3;
        if (ci == ~c) begin
            exp_kind   = 1;
            m_code     = c;
            m_addr     = a;
            held_until = exp_cyc + RW;
        end else begin
            exp_kind = 3;
        end
    endtask

    task automatic model_repeat(input int rise);
        exp_cyc = rise + 3;
        if (exp_cyc - 1 < held_until) begin
            exp_kind   = 2;
            held_until = exp_cyc + RW;
        end else begin
            exp_kind = 0;
        end
    endtask

    task automatic drive(input logic v, input int n);
        ir_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [31:0] w, input int nbits);
        drive(1'b0, 45);
        drive(1'b1, 22);
        for (int i = 0; i < nbits; i++) begin
            drive(1'b0, 3);
            drive(1'b1, w[i] ? 9 : 3);
        end
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] c, input logic [7:0] ci, output int rise);
        send_bits({ci, c, ~a, a}, 32);
        drive(1'b0, 3);
        rise = cyc;
        drive(1'b1, 8);
    endtask

    task automatic send_repeat(output int rise);
        drive(1'b0, 45);
        drive(1'b1, 11);
        drive(1'b0, 3);
        rise = cyc;
        drive(1'b1, 8);
    endtask

    task automatic test_reset;
        checks++; if ({key_valid, key_code, addr, repeat_pulse, key_held, frame_error} !== 20'h0) begin errors++; $display("FAIL reset_outputs got %0h want 0", {key_valid, key_code, addr, repeat_pulse, key_held, frame_error}); end
    endtask

    task automatic test_frame;
        int rise; ev_t ev;
        ev_q.delete();
        send_frame(8'h00, 8'h12, 8'hED, rise);
        model_frame(8'h00, 8'h12, 8'hED, rise);
        ev = '{-1, 0, 8'h00, 8'h00}; if (ev_q.size() > 0) ev = ev_q[0];
        checks++; if (ev_q.size() !== 1) begin errors++; $display("FAIL frame_count got %0d want 1", ev_q.size()); end
        checks++; if (ev.kind !== exp_kind) begin errors++; $display("FAIL frame_kind got %0d want %0d", ev.kind, exp_kind); end
        checks++; if (ev.cyc !== exp_cyc) begin errors++; $display("FAIL frame_latency got %0d want %0d", ev.cyc, exp_cyc); end
        checks++; if ({ev.code, ev.adr} !== {m_code, m_addr}) begin errors++; $display("FAIL frame_data got %h want %h", {ev.code, ev.adr}, {m_code, m_addr}); end
        checks++; if (key_held !== (cyc < held_until)) begin errors++; $display("FAIL frame_held got %b want %b", key_held, cyc < held_until); end
    endtask

    task automatic test_repeat;
        int rise; ev_t ev;
        drive(1'b1, 190);
        ev_q.delete();
        send_repeat(rise);
        model_repeat(rise);
        ev = '{-1, 0, 8'h00, 8'h00}; if (ev_q.size() > 0) ev = ev_q[0];
        checks++; if (ev_q.size() !== 1) begin errors++; $display("FAIL repeat_count got %0d want 1", ev_q.size()); end
        checks++; if (ev.kind !== exp_kind) begin errors++; $display("FAIL repeat_kind got %0d want %0d", ev.kind, exp_kind); end
        checks++; if (ev.cyc !== exp_cyc) begin errors++; $display("FAIL repeat_latency got %0d want %0d", ev.cyc, exp_cyc); end
        checks++; if (key_held !== (cyc < held_until)) begin errors++; $display("FAIL repeat_held got %b want %b", key_held, cyc < held_until); end
        drive(1'b1, 700);
        checks++; if (key_held !== (cyc < held_until)) begin errors++; $display("FAIL expired_held got %b want %b", key_held, cyc < held_until); end
        ev_q.delete();
        send_repeat(rise);
        model_repeat(rise);
        checks++; if (ev_q.size() !== ((exp_kind != 0) ? 1 : 0)) begin errors++; $display("FAIL expired_repeat_count got %0d want %0d", ev_q.size(), (exp_kind != 0) ? 1 : 0); end
    endtask

    task automatic test_bad_complement;
        int rise; ev_t ev;
        ev_q.delete();
        send_frame(8'h00, 8'h1A, 8'hE6, rise);
        model_frame(8'h00, 8'h1A, 8'hE6, rise);
        ev = '{-1, 0, 8'h00, 8'h00}; if (ev_q.size() > 0) ev = ev_q[0];
        checks++; if (ev_q.size() !== 1) begin errors++; $display("FAIL badcmp_count got %0d want 1", ev_q.size()); end
        checks++; if (ev.kind !== exp_kind) begin errors++; $display("FAIL badcmp_kind got %0d want %0d", ev.kind, exp_kind); end
        checks++; if (ev.cyc !== exp_cyc) begin errors++; $display("FAIL badcmp_latency got %0d want %0d", ev.cyc, exp_cyc); end
        checks++; if (key_code !== m_code) begin errors++; $display("FAIL badcmp_code got %h want %h", key_code, m_code); end
    endtask

    task automatic test_timeout;
        int rise, d; ev_t ev;
        logic [7:0] a;
        a = 8'($urandom);
        ev_q.delete();
        send_bits({8'hF0, 8'h0F, ~a, a}, 10);
        drive(1'b0, 3);
        d = cyc;
        drive(1'b1, 80);
        ev = '{-1, 0, 8'h00, 8'h00}; if (ev_q.size() > 0) ev = ev_q[0];
        checks++; if (ev_q.size() !== 1) begin errors++; $display("FAIL timeout_count got %0d want 1", ev_q.size()); end
        checks++; if (ev.kind !== 3) begin errors++; $display("FAIL timeout_kind got %0d want 3", ev.kind); end
        checks++; if (ev.cyc !== d + 4 + TO) begin errors++; $display("FAIL timeout_cycle got %0d want %0d", ev.cyc, d + 4 + TO); end
        ev_q.delete();
        send_frame(a, 8'h0F, 8'hF0, rise);
        model_frame(a, 8'h0F, 8'hF0, rise);
        ev = '{-1, 0, 8'h00, 8'h00}; if (ev_q.size() > 0) ev = ev_q[0];
        checks++; if (ev.kind !== exp_kind || ev_q.size() !== 1) begin errors++; $display("FAIL after_timeout_kind got %0d want %0d", ev.kind, exp_kind); end
        checks++; if ({key_code, addr} !== {m_code, m_addr}) begin errors++; $display("FAIL after_timeout_data got %h want %h", {key_code, addr}, {m_code, m_addr}); end
    endtask

    task automatic test_glitch;
        int rise; ev_t ev;
        ev_q.delete();
        drive(1'b0, 20);
        drive(1'b1, 30);
        checks++; if (ev_q.size() !== 0) begin errors++; $display("FAIL glitch_events got %0d want 0", ev_q.size()); end
        send_frame(8'h5A, 8'h05, 8'hFA, rise);
        model_frame(8'h5A, 8'h05, 8'hFA, rise);
        ev = '{-1, 0, 8'h00, 8'h00}; if (ev_q.size() > 0) ev = ev_q[0];
        checks++; if (ev.kind !== exp_kind || ev.cyc !== exp_cyc) begin errors++; $display("FAIL after_glitch_event got %0d@%0d want %0d@%0d", ev.kind, ev.cyc, exp_kind, exp_cyc); end
        checks++; if (key_code !== m_code) begin errors++; $display("FAIL after_glitch_code got %h want %h", key_code, m_code); end
    endtask

    task automatic test_reset_mid_frame;
        int rise; ev_t ev;
        send_bits({8'hFC, 8'h03, 8'hEE, 8'h11}, 20);
        drive(1'b0, 1);
        #2 rst = 1'b1;
        #1;
        held_until = 0; m_code = 8'h00; m_addr = 8'h00;
        checks++; if ({key_valid, key_code, addr, repeat_pulse, key_held, frame_error} !== 20'h0) begin errors++; $display("FAIL async_reset got %0h want 0", {key_valid, key_code, addr, repeat_pulse, key_held, frame_error}); end
        ir_in = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        drive(1'b1, 10);
        ev_q.delete();
        send_frame(8'h11, 8'h03, 8'hFC, rise);
        model_frame(8'h11, 8'h03, 8'hFC, rise);
        ev = '{-1, 0, 8'h00, 8'h00}; if (ev_q.size() > 0) ev = ev_q[0];
        checks++; if (ev.kind !== exp_kind || ev_q.size() !== 1) begin errors++; $display("FAIL post_reset_kind got %0d want %0d", ev.kind, exp_kind); end
        checks++; if (key_code !== m_code) begin errors++; $display("FAIL post_reset_code got %h want %h", key_code, m_code); end
    endtask

    task automatic test_random;
        int rise, t, gap; ev_t ev;
        logic [7:0] a, c, ci;
        for (int n = 0; n < 8; n++) begin
            t   = $urandom_range(0, 2);
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(620, 700) : $urandom_range(5, 150);
            a   = 8'($urandom);
            c   = 8'($urandom);
            ci  = (t == 1) ? (~c ^ (8'h01 << $urandom_range(0, 7))) : ~c;
            drive(1'b1, gap);
            ev_q.delete();
            if (t == 2) begin
                send_repeat(rise);
                model_repeat(rise);
            end else begin
                send_frame(a, c, ci, rise);
                model_frame(a, c, ci, rise);
            end
            ev = '{-1, 0, 8'h00, 8'h00}; if (ev_q.size() > 0) ev = ev_q[0];
            checks++; if (ev_q.size() !== ((exp_kind != 0) ? 1 : 0) || ev.kind !== exp_kind) begin errors++; $display("FAIL rand%0d_event got %0d x%0d want %0d", n, ev.kind, ev_q.size(), exp_kind); end
            if (exp_kind != 0) begin
                checks++; if (ev.cyc !== exp_cyc) begin errors++; $display("FAIL rand%0d_latency got %0d want %0d", n, ev.cyc, exp_cyc); end
            end
            checks++; if ({key_code, addr} !== {m_code, m_addr}) begin errors++; $display("FAIL rand%0d_data got %h want %h", n, {key_code, addr}, {m_code, m_addr}); end
            checks++; if (key_held !== (cyc < held_until)) begin errors++; $display("FAIL rand%0d_held got %b want %b", n, key_held, cyc < held_until); end
        end
    endtask

    initial begin
        rst   = 1'b1;
        ir_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        drive(1'b1, 10);
        test_frame();
        test_repeat();
        test_bad_complement();
        test_timeout();
        test_glitch();
        test_reset_mid_frame();
        test_random();
        checks++; if (multi !== 0) begin errors++; $display("FAIL exclusive_pulses got %0d want 0", multi); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nec_ir_receiver.md
Name: nec_ir_receiver

Overview:
- Upstream front end for the remote-control calculator.
- Takes the raw demodulated IR receiver line and decodes NEC frames: 9 ms leader, 4.5 ms space, 32 bits sent LSB-first, stop mark. Also decodes NEC repeat codes.
- Delivers a validated 8-bit key code with a one-cycle strobe, plus repeat/hold status. The command FSM consumes these instead of decoding pulse widths itself.
- All timing parameters are clk ticks at 50 MHz.

Parameters:
- LEAD_LOW_MIN, 400000, minimum leader mark length (8 ms).
- LEAD_HIGH_MIN, 200000, minimum leader space for a data frame (4 ms).
- REPEAT_HIGH_MIN, 100000, minimum leader space for a repeat code (2 ms). A space ≥ this and < LEAD_HIGH_MIN is a repeat code.
- BIT_ONE_MIN, 56000, bit-space threshold (1.12 ms). A space ≥ this is a 1, otherwise a 0.
- TIMEOUT, 700000, maximum length of any single level inside a frame (14 ms).
- REPEAT_WINDOW, 6000000, hold window after a valid frame or repeat (120 ms).
- CNT_W, 24, width of the level counter and the window counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- ir_in  in  1  raw receiver output; idle high, mark = low; asynchronous to clk
- key_valid  out  1  one-cycle pulse: new validated frame
- key_code  out  8  command byte of the last valid frame
- addr  out  8  address byte of the last valid frame
- repeat_pulse  out  1  one-cycle pulse: repeat code received while key_held
- key_held  out  1  high while the repeat window is live
- frame_error  out  1  one-cycle pulse: timeout, bad space or complement mismatch

Behaviour:
- Reset (async, active-high) clears everything immediately: all outputs 0, FSM to IDLE, data/bit/level/window counters 0, synchronizer flops 1.
- Input conditioning:
  - 2-flop synchronizer on ir_in; a third flop holds the previous synchronized value.
  - Rise/fall are derived from the synchronized and previous values.
  - The level counter clears on every edge and otherwise increments, saturating at TIMEOUT.
- FSM states: IDLE, LEAD_LOW, LEAD_HIGH, BIT_MARK, BIT_SPACE, STOP_MARK, REPEAT_MARK.
- IDLE: fall → LEAD_LOW.
- LEAD_LOW, on rise:
  - count ≥ LEAD_LOW_MIN → LEAD_HIGH.
  - otherwise → IDLE silently (glitch; no error).
- LEAD_HIGH, on fall:
  - count ≥ LEAD_HIGH_MIN → BIT_MARK, bit index = 0.
  - else count ≥ REPEAT_HIGH_MIN → REPEAT_MARK.
  - else frame_error, → IDLE.
- BIT_MARK: rise → BIT_SPACE. Mark width is not checked except by timeout.
- BIT_SPACE, on fall:
  - data[bit index] = (count ≥ BIT_ONE_MIN).
  - bit index 31 → STOP_MARK; otherwise index+1 → BIT_MARK.
- STOP_MARK, on rise, check data[31:24] == ~data[23:16]:
  - Match: key_code = data[23:16], addr = data[7:0], key_valid pulse, window reloaded to REPEAT_WINDOW, key_held = 1.
  - Mismatch: frame_error pulse; key_code and addr unchanged.
  - Either way → IDLE.
- REPEAT_MARK, on rise:
  - key_held = 1 → repeat_pulse, window reloaded.
  - key_held = 0 → repeat ignored, no pulse.
  - Either way → IDLE.
- Address complement is not checked (extended NEC addresses are allowed).
- Timeout: in any non-IDLE state, level counter reaching TIMEOUT → frame_error pulse, → IDLE. Partial data is discarded and outputs are unchanged. A stuck-low line is flagged once; IDLE then waits for the next fall, which requires a rise first.
- Window counter:
  - Decrements each cycle while nonzero; key_held = (counter ≠ 0).
  - A reload in the same cycle as expiry wins, so key_held stays 1.
- Latency: key_valid / repeat_pulse / frame_error assert on the 3rd clk rising edge after the qualifying ir_in edge (2 sync stages + 1 registered output), for exactly one cycle.
- At most one of key_valid, repeat_pulse, frame_error is high in any cycle.
- A new leader arriving while key_held is decoded normally.

Test Plan (sim overrides: LEAD_LOW_MIN=40, LEAD_HIGH_MIN=20, REPEAT_HIGH_MIN=10, BIT_ONE_MIN=6, TIMEOUT=70, REPEAT_WINDOW=600; bench drives leader 45L/22H, bits 3L + 3H(0) or 9H(1), stop 3L, repeat 45L/11H/3L):
1. Frame addr 0x00, cmd 0x12, ~cmd 0xED → key_valid once 3 clks after stop rise, key_code=0x12, addr=0x00, key_held=1, no frame_error.
2. Frame cmd 0x1A with complement byte 0xE6 (wrong) → frame_error once; key_code remains 0x12; key_valid stays 0.
3. Repeat code 200 clks after test 1 → repeat_pulse once, key_held stays 1. Repeat sent 700 clks after last pulse (key_held=0) → no repeat_pulse, no error.
4. Line held high 80 clks during bit 10 of a frame → frame_error once, FSM IDLE. Next good frame cmd 0x0F → key_code=0x0F.
5. Leader mark of only 20 clks, then high → no pulses at all. A following good frame cmd 0x05 decodes correctly.
6. rst asserted mid-frame at bit 20 → all outputs 0 immediately (async). After release, frame cmd 0x03 → key_valid, key_code=0x03.
